// File: rtl/ts_cc_error_monitor.sv
// ts_cc_error_monitor
// Multi-channel MPEG-2 TS continuity-counter checker. Each channel parses its
// own byte-serial transport stream, tracks the CC of one selected PID and
// counts lost or out-of-order packets in a saturating per-channel counter.
//
// Optional feature macro: CC_DUPLICATE_TOL_EN
//   defined   : one duplicate payload packet per CC value is tolerated; a
//               second consecutive duplicate is counted as an error.
//   undefined : every payload packet repeating last_cc is an error and the
//               duplicate-tracking flag is not built.
module ts_cc_error_monitor #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  parameter int PKT_LEN = 188
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       valid,
  input  logic [N_CH-1:0]       sync,
  input  logic [8*N_CH-1:0]     data,
  input  logic [13*N_CH-1:0]    pid_filter,
  input  logic                  en_reset_counter,
  input  logic [N_CH-1:0]       ch_clear,
  output logic [CNT_W*N_CH-1:0] error_count,
  output logic [N_CH-1:0]       error_pulse,
  output logic [N_CH-1:0]       locked
);

  localparam int                BC_W       = $clog2(PKT_LEN);
  // Byte index of the first body byte (sync + three header bytes precede it).
  localparam logic [BC_W-1:0]   BODY_FIRST = BC_W'(4);
  localparam logic [BC_W-1:0]   BODY_LAST  = BC_W'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [12:0]       PID_NULL   = 13'h1FFF;
  localparam logic [7:0]        SYNC_BYTE  = 8'h47;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR1 = 3'd1,
    S_HDR2 = 3'd2,
    S_HDR3 = 3'd3,
    S_BODY = 3'd4
  } state_t;

  // CC the next packet must carry: payload packets advance the counter
  // (15 wraps to 0), adaptation-only / reserved packets repeat it.
  function automatic logic [3:0] cc_expected(input logic [3:0] last_cc,
                                             input logic       payload);
    logic [3:0] nxt;
    if (payload) begin
      nxt = last_cc + 4'd1;
    end else begin
      nxt = last_cc;
    end
    return nxt;
  endfunction

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nxt;
      logic [BC_W-1:0]  r_byte_cnt;
      logic [BC_W-1:0]  w_byte_cnt_nxt;
      logic             r_tei;
      logic             w_tei_nxt;
      logic [12:0]      r_pid;
      logic [12:0]      w_pid_nxt;
      logic             w_hdr3_acc;

      logic [7:0]       w_byte;
      logic             w_sync_hit;
      logic [12:0]      w_filter;
      logic             w_pid_ok;
      logic             w_eval;
      logic [3:0]       w_cc;
      logic             w_payload;
      logic [3:0]       w_cc_exp;
      logic             w_clr;
      logic             w_err;

      logic [3:0]       r_last_cc;
      logic             r_locked;
      logic [CNT_W-1:0] r_count;
      logic             r_pulse;

      assign w_byte     = data[8*g +: 8];
      assign w_filter   = pid_filter[13*g +: 13];
      // A qualified 0x47 sync byte always (re)starts header parsing.
      assign w_sync_hit = valid[g] & sync[g] & (w_byte == SYNC_BYTE);

      // Parser state register.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state    <= S_IDLE;
          r_byte_cnt <= '0;
          r_tei      <= 1'b0;
          r_pid      <= 13'h0000;
        end else begin
          r_state    <= w_state_nxt;
          r_byte_cnt <= w_byte_cnt_nxt;
          r_tei      <= w_tei_nxt;
          r_pid      <= w_pid_nxt;
        end
      end

      // Parser next-state: header field capture and body byte counting.
      always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_tei_nxt      = r_tei;
        w_pid_nxt      = r_pid;
        w_hdr3_acc     = 1'b0;
        if (w_sync_hit) begin
          w_state_nxt = S_HDR1;
        end else if (valid[g]) begin
          case (r_state)
            S_IDLE: begin
              w_state_nxt = S_IDLE;
            end
            S_HDR1: begin
              w_tei_nxt   = w_byte[7];
              w_pid_nxt   = {w_byte[4:0], r_pid[7:0]};
              w_state_nxt = S_HDR2;
            end
            S_HDR2: begin
              w_pid_nxt   = {r_pid[12:8], w_byte};
              w_state_nxt = S_HDR3;
            end
            S_HDR3: begin
              w_hdr3_acc     = 1'b1;
              w_byte_cnt_nxt = BODY_FIRST;
              w_state_nxt    = S_BODY;
            end
            S_BODY: begin
              if (r_byte_cnt == BODY_LAST) begin
                w_state_nxt = S_IDLE;
              end else begin
                w_byte_cnt_nxt = r_byte_cnt + BC_W'(1);
              end
            end
            default: begin
              w_state_nxt = S_IDLE;
            end
          endcase
        end else begin
          w_state_nxt = r_state;
        end
      end

      // Packet evaluation happens on the accepted HDR3 byte.
      assign w_pid_ok  = (r_pid == w_filter) & (r_pid != PID_NULL) & ~r_tei;
      assign w_eval    = w_hdr3_acc & w_pid_ok;
      assign w_cc      = w_byte[3:0];
      assign w_payload = w_byte[4];
      assign w_cc_exp  = cc_expected(r_last_cc, w_payload);
      assign w_clr     = en_reset_counter | ch_clear[g];

`ifdef CC_DUPLICATE_TOL_EN
      logic r_dup;
      logic w_is_dup;
      logic w_dup_nxt;

      // A payload packet repeating last_cc is a duplicate; the first one is
      // forgiven and remembered, the next consecutive one is an error.
      assign w_is_dup = r_locked & w_payload & (w_cc == r_last_cc);
      assign w_err    = w_eval & r_locked & (w_cc != w_cc_exp) &
                        ~(w_is_dup & ~r_dup);

      // Duplicate flag follows the latest evaluated packet.
      always_comb begin
        w_dup_nxt = r_dup;
        if (w_clr) begin
          w_dup_nxt = 1'b0;
        end else if (w_eval) begin
          w_dup_nxt = w_is_dup;
        end else begin
          w_dup_nxt = r_dup;
        end
      end

      // Duplicate flag register.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_dup <= 1'b0;
        end else begin
          r_dup <= w_dup_nxt;
        end
      end
`else
      assign w_err = w_eval & r_locked & (w_cc != w_cc_exp);
`endif

      // CC reference, lock, saturating error counter and error pulse.
      // A clear overrides the counter and lock but never the pulse.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_last_cc <= 4'h0;
          r_locked  <= 1'b0;
          r_count   <= '0;
          r_pulse   <= 1'b0;
        end else begin
          r_pulse <= w_err;
          if (w_eval) begin
            r_last_cc <= w_cc;
          end
          if (w_clr) begin
            r_locked <= 1'b0;
            r_count  <= '0;
          end else begin
            if (w_eval) begin
              r_locked <= 1'b1;
            end
            if (w_err && (r_count != CNT_MAX)) begin
              r_count <= r_count + CNT_ONE;
            end
          end
        end
      end

      assign error_count[CNT_W*g +: CNT_W] = r_count;
      assign error_pulse[g]                = r_pulse;
      assign locked[g]                     = r_locked;
    end
  endgenerate

endmodule

// File: tb/tb_ts_cc_error_monitor.sv
// Bench for ts_cc_error_monitor: packet-level reference model of CC checking,
// per-cycle comparison of all outputs plus hand-computed literal checks.
module tb_ts_cc_error_monitor;
  localparam int N_CH    = 4;
  localparam int CNT_W   = 4;
  localparam int PKT_LEN = 188;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_CH-1:0]       valid;
  logic [N_CH-1:0]       sync;
  logic [8*N_CH-1:0]     data;
  logic [13*N_CH-1:0]    pid_filter;
  logic                  en_reset_counter;
  logic [N_CH-1:0]       ch_clear;
  logic [CNT_W*N_CH-1:0] error_count;
  logic [N_CH-1:0]       error_pulse;
  logic [N_CH-1:0]       locked;

  always #5 clk = ~clk;

  ts_cc_error_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .reset(reset), .valid(valid), .sync(sync), .data(data),
    .pid_filter(pid_filter), .en_reset_counter(en_reset_counter),
    .ch_clear(ch_clear), .error_count(error_count),
    .error_pulse(error_pulse), .locked(locked)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_print = 0;
  bit chk_on = 1'b0;

  // reference model state (packet level)
  int exp_cnt[N_CH];
  bit exp_pulse[N_CH];
  bit exp_lock[N_CH];
  int m_last[N_CH];
  bit m_dup[N_CH];
  int pulse_seen[N_CH];

  // header of a packet whose HDR3 byte is on the wires this cycle
  bit pend_v[N_CH];
  int pend_pid[N_CH], pend_tei[N_CH], pend_afc[N_CH], pend_cc[N_CH];

  // packet descriptors for the next send_pkts call
  bit         p_en[N_CH];
  logic [12:0] p_pid[N_CH];
  logic       p_tei[N_CH];
  logic [1:0] p_afc[N_CH];
  logic [3:0] p_cc[N_CH];
  int         p_trunc[N_CH];
  bit         p_clrh[N_CH];
  bit         p_ilv = 1'b0;

  function automatic int cnt_of(input int ch);
    return int'(error_count[CNT_W*ch +: CNT_W]);
  endfunction

  task automatic check_lit(input string name, input int got, input int expv);
    n_chk++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  // Apply the CC rules to what the DUT samples at this clock edge.
  task automatic model_step();
    for (int ch = 0; ch < N_CH; ch++) begin
      bit err;
      bit clr;
      bit payload;
      int expcc;
      err = 1'b0;
      clr = en_reset_counter || ch_clear[ch];
      if (reset) begin
        exp_cnt[ch] = 0; exp_lock[ch] = 1'b0; exp_pulse[ch] = 1'b0;
        m_last[ch] = 0; m_dup[ch] = 1'b0; pend_v[ch] = 1'b0;
      end else begin
        if (pend_v[ch]) begin
          pend_v[ch] = 1'b0;
          if (pend_pid[ch] == int'(pid_filter[13*ch +: 13]) &&
              pend_pid[ch] != 'h1FFF && pend_tei[ch] == 0) begin
            payload = (pend_afc[ch] == 1) || (pend_afc[ch] == 3);
            expcc = payload ? (m_last[ch] + 1) % 16 : m_last[ch];
            if (!exp_lock[ch]) begin
              exp_lock[ch] = 1'b1; m_dup[ch] = 1'b0;
            end else if (pend_cc[ch] == expcc) begin
              m_dup[ch] = 1'b0;
            end else if (payload && pend_cc[ch] == m_last[ch]) begin
`ifdef CC_DUPLICATE_TOL_EN
              if (m_dup[ch]) err = 1'b1;
              m_dup[ch] = 1'b1;
`else
              err = 1'b1;
`endif
            end else begin
              err = 1'b1; m_dup[ch] = 1'b0;
            end
            m_last[ch] = pend_cc[ch];
            if (err && exp_cnt[ch] < CNT_MAX) exp_cnt[ch] = exp_cnt[ch] + 1;
          end
        end
        if (clr) begin
          exp_cnt[ch] = 0; exp_lock[ch] = 1'b0; m_dup[ch] = 1'b0;
        end
        exp_pulse[ch] = err;
      end
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compare DUT outputs against the model on every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        n_chk++;
        if (error_pulse[ch] === 1'b1) pulse_seen[ch]++;
        if (cnt_of(ch) != exp_cnt[ch] || error_pulse[ch] !== exp_pulse[ch] ||
            locked[ch] !== exp_lock[ch]) begin
          n_fail++;
          if (n_print < 30) begin
            n_print++;
            $display("FAIL cycle_cmp ch%0d t=%0t: count %0d/%0d pulse %0b/%0b locked %0b/%0b (got/expected)",
                     ch, $time, cnt_of(ch), exp_cnt[ch], error_pulse[ch], exp_pulse[ch],
                     locked[ch], exp_lock[ch]);
          end
        end
      end
    end
  end

  function automatic logic [7:0] pkt_byte(input int ch, input int i);
    logic [12:0] pid;
    logic [7:0]  b;
    pid = p_pid[ch];
    b = 8'(i);
    case (i)
      0: b = 8'h47;
      1: b = {p_tei[ch], 2'b00, pid[12:8]};
      2: b = pid[7:0];
      3: b = {2'b00, p_afc[ch], p_cc[ch]};
      default: b = 8'(i);
    endcase
    return b;
  endfunction

  task automatic set_pkt(input int ch, input int pid, input int tei, input int afc, input int cc);
    p_en[ch] = 1'b1; p_pid[ch] = 13'(pid); p_tei[ch] = tei[0];
    p_afc[ch] = 2'(afc); p_cc[ch] = 4'(cc);
  endtask

  // Send one packet on every enabled channel, byte-serially in parallel.
  task automatic send_pkts();
    int idx[N_CH];
    int len;
    int cyc;
    bit busy;
    cyc = 0;
    busy = 1'b1;
    for (int ch = 0; ch < N_CH; ch++) idx[ch] = 0;
    while (busy) begin
      step_edge();
      valid = '0; sync = '0; data = '0; en_reset_counter = 1'b0; ch_clear = '0;
      busy = 1'b0;
      for (int ch = 0; ch < N_CH; ch++) begin
        len = (p_trunc[ch] != 0) ? p_trunc[ch] : PKT_LEN;
        if (p_en[ch] && idx[ch] < len) begin
          busy = 1'b1;
          if (!p_ilv || (cyc % (ch + 1)) == 0) begin
            valid[ch] = 1'b1;
            sync[ch] = (idx[ch] == 0);
            data[8*ch +: 8] = pkt_byte(ch, idx[ch]);
            if (idx[ch] == 3) begin
              pend_v[ch] = 1'b1; pend_pid[ch] = int'(p_pid[ch]);
              pend_tei[ch] = int'(p_tei[ch]); pend_afc[ch] = int'(p_afc[ch]);
              pend_cc[ch] = int'(p_cc[ch]);
              if (p_clrh[ch]) en_reset_counter = 1'b1;
            end
            idx[ch]++;
          end
        end
      end
      cyc++;
      if (cyc > 5000) begin
        check_lit("send_timeout", cyc, 5000);
        busy = 1'b0;
      end
    end
    for (int ch = 0; ch < N_CH; ch++) begin
      p_en[ch] = 1'b0; p_trunc[ch] = 0; p_clrh[ch] = 1'b0;
    end
  endtask

  task automatic do_clear(input logic [N_CH-1:0] m);
    step_edge();
    valid = '0; sync = '0; en_reset_counter = 1'b0; ch_clear = m;
    step_edge();
    ch_clear = '0;
  endtask

  task automatic set_filter(input int ch, input int pid);
    pid_filter[13*ch +: 13] = 13'(pid);
  endtask

  initial begin
    reset = 1'b1; valid = '0; sync = '0; data = '0;
    en_reset_counter = 1'b0; ch_clear = '0; pid_filter = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      p_en[ch] = 1'b0; p_trunc[ch] = 0; p_clrh[ch] = 1'b0; pulse_seen[ch] = 0;
    end
    set_filter(0, 'h100); set_filter(1, 'h1FFF); set_filter(2, 'h102); set_filter(3, 'h200);
    step_edge();
    chk_on = 1'b1;
    step_edge();
    step_edge();
    check_lit("reset_count", int'(error_count), 0);
    check_lit("reset_locked", int'(locked), 0);
    check_lit("reset_pulse", int'(error_pulse), 0);
    reset = 1'b0;

    // in-order CC 0..15,0..3 on channel 0
    for (int k = 0; k < 20; k++) begin
      set_pkt(0, 'h100, 0, 1, k % 16);
      send_pkts();
    end
    check_lit("seq_locked0", int'(locked[0]), 1);
    check_lit("seq_count0", cnt_of(0), 0);
    check_lit("seq_pulses0", pulse_seen[0], 0);

    // 3 (last), 4, 6, 7 -> one error at CC 6
    pulse_seen[0] = 0;
    set_pkt(0, 'h100, 0, 1, 4); send_pkts();
    set_pkt(0, 'h100, 0, 1, 6); send_pkts();
    set_pkt(0, 'h100, 0, 1, 7); send_pkts();
    check_lit("gap_count0", cnt_of(0), 1);
    check_lit("gap_pulses0", pulse_seen[0], 1);

    // duplicates 5,5,5
    do_clear(4'b0001);
    check_lit("clr_count0", cnt_of(0), 0);
    check_lit("clr_locked0", int'(locked[0]), 0);
    for (int k = 0; k < 3; k++) begin
      set_pkt(0, 'h100, 0, 1, 5); send_pkts();
    end
`ifdef CC_DUPLICATE_TOL_EN
    check_lit("dup_count0", cnt_of(0), 1);
`else
    check_lit("dup_count0", cnt_of(0), 2);
`endif

    // adaptation-only repeats, null PID and TEI packets are not errors
    do_clear(4'b0001);
    set_pkt(0, 'h100, 0, 1, 9); send_pkts();
    set_pkt(0, 'h100, 0, 2, 9); send_pkts();
    set_pkt(0, 'h100, 0, 2, 9); send_pkts();
    set_pkt(0, 'h100, 0, 0, 9); send_pkts();
    for (int k = 0; k < 3; k++) begin
      set_pkt(0, 'h100, 1, 1, 2 + k);
      set_pkt(1, 'h1FFF, 0, 1, int'($urandom_range(0, 15)));
      send_pkts();
    end
    set_pkt(0, 'h100, 0, 1, 10); send_pkts();
    check_lit("afc_tei_count0", cnt_of(0), 0);
    check_lit("afc_tei_locked0", int'(locked[0]), 1);
    check_lit("null_locked1", int'(locked[1]), 0);
    check_lit("null_count1", cnt_of(1), 0);

    // saturation: lock then 20 errors on channel 3
    pulse_seen[3] = 0;
    for (int k = 0; k < 21; k++) begin
      set_pkt(3, 'h200, 0, 3, (2 * k) % 16); send_pkts();
    end
    check_lit("sat_count3", cnt_of(3), 15);
    check_lit("sat_pulses3", pulse_seen[3], 20);
    // error on the same cycle as en_reset_counter
    set_pkt(3, 'h200, 0, 1, 0); p_clrh[3] = 1'b1; send_pkts();
    check_lit("clr_err_count3", cnt_of(3), 0);
    check_lit("clr_err_locked3", int'(locked[3]), 0);
    check_lit("clr_err_pulses3", pulse_seen[3], 21);
    check_lit("clr_all_locked0", int'(locked[0]), 0);

    // four interleaved channels, channel 2 erroring each packet
    set_filter(1, 'h101); set_filter(2, 'h102); set_filter(3, 'h103);
    p_ilv = 1'b1;
    for (int r = 0; r < 5; r++) begin
      set_pkt(0, 'h100, 0, 1, r);
      set_pkt(1, 'h101, 0, 1, r + 5);
      set_pkt(2, 'h102, 0, 1, (3 * r) % 16);
      set_pkt(3, 'h103, 0, 1, (15 + r) % 16);
      send_pkts();
    end
    check_lit("ilv_count2", cnt_of(2), 4);
    check_lit("ilv_count0", cnt_of(0), 0);
    check_lit("ilv_count3", cnt_of(3), 0);
    do_clear(4'b0100);
    check_lit("chclr_count2", cnt_of(2), 0);
    check_lit("chclr_locked2", int'(locked[2]), 0);
    check_lit("chclr_locked0", int'(locked[0]), 1);
    // truncated body on channel 1 followed by a restart
    set_pkt(0, 'h100, 0, 1, 5); set_pkt(1, 'h101, 0, 1, 10); p_trunc[1] = 100;
    set_pkt(2, 'h102, 0, 1, 15); set_pkt(3, 'h103, 0, 1, 4);
    send_pkts();
    set_pkt(0, 'h100, 0, 1, 6); set_pkt(1, 'h101, 0, 1, 11);
    set_pkt(2, 'h102, 0, 1, 2); set_pkt(3, 'h103, 0, 1, 5);
    send_pkts();
    check_lit("restart_count1", cnt_of(1), 0);
    check_lit("relock_count2", cnt_of(2), 1);
    step_edge();
    step_edge();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_cc_error_monitor.md
# ts_cc_error_monitor

Parametrised multi-channel MPEG-2 TS continuity-counter (CC) checker for the QoS path. It parses N_CH independent byte-serial transport streams and tracks the CC of one selected PID per channel. Each lost or out-of-order packet increments a saturating per-channel error counter and raises a one-cycle error pulse. It replaces fixed 4-channel, 8-bit CC counter arrays and adds PID filtering, TS header decoding, duplicate handling, saturation and per-channel clear.

## Interface
- N_CH, 4: number of TS channels (1..16)
- CNT_W, 16: error counter width per channel (4..32)
- PKT_LEN, 188: TS packet length in bytes

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- valid  in  N_CH  byte strobe per channel
- sync  in  N_CH  first byte of packet, qualified by valid
- data  in  8*N_CH  channel i at [8i+7:8i]
- pid_filter  in  13*N_CH  PID monitored by channel i at [13i+12:13i]
- en_reset_counter  in  1  clear all counters and CC lock state
- ch_clear  in  N_CH  per-channel clear of counter and lock
- error_count  out  CNT_W*N_CH  channel i at [CNT_W*i+CNT_W-1:CNT_W*i]
- error_pulse  out  N_CH  one-cycle pulse per detected CC error
- locked  out  N_CH  channel holds a reference CC

## Operation
- Each channel runs an independent FSM: IDLE, HDR1, HDR2, HDR3, BODY. Bytes are consumed only when valid is high.
- IDLE → HDR1 when valid, sync and data==0x47. Sync with any other byte is ignored and the FSM stays in IDLE.
- HDR1 captures TEI (bit 7) and PID[12:8]. HDR2 captures PID[7:0]. HDR3 captures AFC (bits 5:4) and CC (bits 3:0), evaluates the packet, then moves to BODY.
- BODY counts bytes up to PKT_LEN-1 and then returns to IDLE.
- valid&sync&0x47 in any non-IDLE state restarts at HDR1. The truncated packet is dropped with no error.
- Evaluation happens only when PID==pid_filter[i], PID!=0x1FFF and TEI==0. All other packets are ignored.
- A packet carries payload when AFC is 01 or 11. The expected CC is last_cc+1 mod 16 for payload packets and last_cc for AFC 00/10. AFC 00 is reserved and treated like 10.
- If not locked: store CC, set locked, no error.
- If locked and CC==expected: store CC, no error.
- If locked, payload packet, and CC==last_cc: this is a duplicate. See Configuration.
- Any other CC is an error. Store the received CC as the new reference, increment error_count[i] and pulse error_pulse[i].
- error_count saturates at 2^CNT_W-1. error_pulse still fires at saturation.
- en_reset_counter clears all channels. ch_clear[i] clears channel i only. Both zero the counter and locked but do not disturb the parser FSM.

## Timing
- Reset values: error_count=0, error_pulse=0, locked=0, all FSMs in IDLE, last_cc=0, duplicate flag=0.
- Latency: the HDR3 byte accepted in cycle t produces updated error_count, error_pulse and locked in cycle t+1.
- error_pulse is high for exactly one cycle per error.
- Clear asserted in cycle t makes count and locked zero in cycle t+1. A clear wins over an error evaluated in the same cycle: count=0, locked=0, and the pulse still fires.
- A packet evaluated in the same cycle as a clear does not lock the channel.
- Channels are fully independent, and simultaneous errors on all channels are all counted.
- CC 15→0 is a valid increment.
- Reset mid-packet returns the FSM to IDLE with no error.
- A change to pid_filter takes effect at the next HDR3. It does not clear lock; software issues ch_clear when retargeting.

## Configuration
- CC_DUPLICATE_TOL_EN defined: one duplicate per CC value is tolerated. A second consecutive duplicate is an error. The duplicate flag clears on any non-duplicate evaluated packet.
- CC_DUPLICATE_TOL_EN undefined: any payload packet with CC==last_cc is an error. The duplicate flag logic is removed.

## Test plan
- Channel 0, PID 0x100, AFC 01, CC 0..15,0..3 (20 packets) → locked=1 after first, error_count[0]=0, no pulses.
- CC sequence 3,4,6 on PID 0x100 → one error_pulse one cycle after the HDR3 byte of CC=6, count=1; next CC=7 gives no error.
- CC sequence 5,5,5 payload → with CC_DUPLICATE_TOL_EN count=1 (third packet); without it count=2.
- AFC 10 packets with CC 9,9 after 9 → no error. PID 0x1FFF or TEI=1 packets with random CC → ignored, count unchanged.
- CNT_W=4 with 20 forced CC errors → count sticks at 15 and 20 pulses are seen. en_reset_counter in the same cycle as an error → count=0, locked=0.
- All 4 channels with interleaved valid and channel 2 erroring each packet → only error_count[2] increments. ch_clear[2] zeros only channel 2. A sync restart mid-body causes no error.
